// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - immediate/load-data extension unit with 2-entry skid output buffer
module ext_pipe #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 8,
  localparam int SEL_W = $clog2(WORD_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [2:0]        in_mode,
  input  logic [SEL_W-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] skid_word;
  logic              skid_err;

  logic [WORD_W-1:0] res_word;
  logic              res_err;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic              acc;
  logic              pop;

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  // Byte lane picked by the full offset, halfword lane by the offset with bit 0 dropped
  assign byte_lane = in_data[{in_sel, 3'b000} +: 8];
  assign half_lane = in_data[{in_sel[SEL_W-1:1], 4'b0000} +: 16];

  // Extension of the incoming request; erroneous requests produce a zero word
  always_comb begin
    res_word = '0;
    res_err  = 1'b0;
    case (in_mode)
      3'd0: res_word = {{(WORD_W-16){1'b0}}, in_data[15:0]};
      3'd1: res_word = {{(WORD_W-16){in_data[15]}}, in_data[15:0]};
      3'd2: res_word = {{(WORD_W-16){in_data[15]}}, in_data[15:0]} << 16;
      3'd3: res_word = {{(WORD_W-8){byte_lane[7]}}, byte_lane};
      3'd4: res_word = {{(WORD_W-8){1'b0}}, byte_lane};
      3'd5: begin
        if (in_sel[0]) res_err = 1'b1;
        else           res_word = {{(WORD_W-16){half_lane[15]}}, half_lane};
      end
      3'd6: begin
        if (in_sel[0]) res_err = 1'b1;
        else           res_word = {{(WORD_W-16){1'b0}}, half_lane};
      end
      default: res_err = 1'b1;
    endcase
  end

  // Buffer FSM: main entry drives the outputs, skid absorbs one extra result under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_err   <= 1'b0;
      skid_word <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready  <= 1'b1;
          out_valid <= acc;
          if (acc) begin
            out_word <= res_word;
            out_err  <= res_err;
            state    <= ONE;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            skid_word <= res_word;
            skid_err  <= res_err;
            state     <= TWO;
            in_ready  <= 1'b0;
          end else if (!acc && pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (acc && pop) begin
            out_word <= res_word;
            out_err  <= res_err;
          end
        end
        TWO: begin
          if (pop) begin
            out_word <= skid_word;
            out_err  <= skid_err;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of erroneous requests, taken at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (acc && res_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - scoreboard bench for ext_pipe at 32-bit and 64-bit widths
module tb_ext_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, oe32;
  logic [31:0] id32 = '0, ow32;
  logic [2:0]  im32 = '0;
  logic [1:0]  is32 = '0;
  logic [1:0]  ec32;

  logic        iv64 = 1'b0, ir64, ov64, or64 = 1'b0, oe64;
  logic [63:0] id64 = '0, ow64;
  logic [2:0]  im64 = '0;
  logic [2:0]  is64 = '0;
  logic [7:0]  ec64;

  ext_pipe #(.WORD_W(32), .CNT_W(2)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .in_mode(im32), .in_sel(is32), .out_valid(ov32), .out_ready(or32),
    .out_word(ow32), .out_err(oe32), .err_cnt(ec32));

  ext_pipe #(.WORD_W(64), .CNT_W(8)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .in_mode(im64), .in_sel(is64), .out_valid(ov64), .out_ready(or64),
    .out_word(ow64), .out_err(oe64), .err_cnt(ec64));

  int n_cmp = 0;
  int n_fail = 0;
  logic [64:0] q32[$];
  logic [64:0] q64[$];
  int exp_cnt32 = 0;
  int exp_cnt64 = 0;

  task automatic cmp(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {err, word} computed with plain arithmetic on 64-bit values
  function automatic logic [64:0] model(input int w, input logic [2:0] mode,
                                        input logic [63:0] d, input int sel);
    longint unsigned v = 0;
    longint unsigned mask;
    bit err = 0;
    mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    case (mode)
      3'd0: v = d & 64'hFFFF;
      3'd1: begin v = d & 64'hFFFF; if (v >= 64'h8000) v = v - 64'h10000; end
      3'd2: begin
        v = (d & 64'hFFFF) * 64'h10000;
        if (v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
      3'd3, 3'd4: begin
        v = (d >> (8 * sel)) & 64'hFF;
        if (mode == 3'd3 && v >= 64'h80) v = v - 64'h100;
      end
      3'd5, 3'd6: begin
        if (sel % 2 == 1) err = 1;
        else begin
          v = (d >> (16 * (sel / 2))) & 64'hFFFF;
          if (mode == 3'd5 && v >= 64'h8000) v = v - 64'h10000;
        end
      end
      default: err = 1;
    endcase
    if (err) v = 0;
    return {err, v & mask};
  endfunction

  // Scoreboard for the 32-bit instance: record accepts, check pops and the error count
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      q32.delete();
      exp_cnt32 = 0;
      cmp("rst32_out_valid", {64'd0, ov32}, 65'd0);
    end else begin
      cmp("err_cnt32", {63'd0, ec32}, 65'(exp_cnt32));
      if (ov32 && or32) begin
        if (q32.size() == 0) cmp("pop32_unexpected", {oe32, 32'd0, ow32}, 65'h1_DEAD_BEEF);
        else begin
          e = q32.pop_front();
          cmp("pop32", {oe32, 32'd0, ow32}, e);
        end
      end
      if (iv32 && ir32) begin
        e = model(32, im32, {32'd0, id32}, int'(is32));
        q32.push_back(e);
        if (e[64]) exp_cnt32 = (exp_cnt32 == 3) ? 3 : exp_cnt32 + 1;
      end
    end
  end

  // Scoreboard for the 64-bit instance
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      q64.delete();
      exp_cnt64 = 0;
    end else begin
      cmp("err_cnt64", {57'd0, ec64}, 65'(exp_cnt64));
      if (ov64 && or64) begin
        if (q64.size() == 0) cmp("pop64_unexpected", {oe64, ow64}, 65'h1_DEAD_BEEF);
        else begin
          e = q64.pop_front();
          cmp("pop64", {oe64, ow64}, e);
        end
      end
      if (iv64 && ir64) begin
        e = model(64, im64, id64, int'(is64));
        q64.push_back(e);
        if (e[64]) exp_cnt64 = (exp_cnt64 == 255) ? 255 : exp_cnt64 + 1;
      end
    end
  end

  task automatic send32(input logic [2:0] m, input logic [31:0] d, input logic [1:0] s);
    int n = 0;
    iv32 = 1'b1; id32 = d; im32 = m; is32 = s;
    @(negedge clk);
    while (!ir32 && n < 50) begin @(negedge clk); n++; end
    if (!ir32) cmp("send32_timeout", 65'd0, 65'd1);
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  task automatic send64(input logic [2:0] m, input logic [63:0] d, input logic [2:0] s);
    int n = 0;
    iv64 = 1'b1; id64 = d; im64 = m; is64 = s;
    @(negedge clk);
    while (!ir64 && n < 50) begin @(negedge clk); n++; end
    if (!ir64) cmp("send64_timeout", 65'd0, 65'd1);
    @(posedge clk); #1;
    iv64 = 1'b0;
  endtask

  task automatic tick; @(posedge clk); #1; endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_in_ready", {64'd0, ir32}, 65'd0);
    cmp("rst_out_word", {oe32, 32'd0, ow32}, 65'd0);
    cmp("rst_err_cnt", {63'd0, ec32}, 65'd0);
    rst = 1'b0;
    tick();
    cmp("in_ready_after_rst", {64'd0, ir32}, 65'd1);

    // Basic extensions with free-flowing output
    or32 = 1'b1;
    send32(3'd1, 32'h0000_8001, 2'd0);
    cmp("sext16", {ov32, oe32, ow32}, {31'd0, 2'b10, 32'hFFFF_8001});
    send32(3'd0, 32'h0000_8001, 2'd0);
    cmp("zext16", {ov32, oe32, ow32}, {31'd0, 2'b10, 32'h0000_8001});
    send32(3'd3, 32'h12F4_5678, 2'd2);
    cmp("lb", {oe32, ow32}, {32'd0, 1'b0, 32'hFFFF_FFF4});
    send32(3'd4, 32'h12F4_5678, 2'd2);
    cmp("lbu", {oe32, ow32}, {32'd0, 1'b0, 32'h0000_00F4});
    send32(3'd5, 32'h12F4_5678, 2'd2);
    cmp("lh", {oe32, ow32}, {32'd0, 1'b0, 32'h0000_12F4});
    send32(3'd6, 32'h12F4_5678, 2'd1);
    cmp("lhu_misaligned", {oe32, ow32}, {32'd0, 1'b1, 32'h0});
    cmp("err_cnt_one", {63'd0, ec32}, 65'd1);
    tick();
    tick();

    // Backpressure: fill both entries, then drain in order
    or32 = 1'b0;
    send32(3'd0, 32'h0000_1111, 2'd0);
    send32(3'd0, 32'h0000_2222, 2'd0);
    cmp("bp_full", {ov32, ir32, ow32}, {31'd0, 2'b10, 32'h0000_1111});
    or32 = 1'b1;
    tick();
    cmp("bp_second", {ov32, ir32, ow32}, {31'd0, 2'b11, 32'h0000_2222});
    tick();
    cmp("bp_drained", {64'd0, ov32}, 65'd0);
    send32(3'd0, 32'h0000_3333, 2'd0);
    send32(3'd0, 32'h0000_4444, 2'd0);
    cmp("acc_and_pop", {ov32, ir32, ow32}, {31'd0, 2'b11, 32'h0000_4444});
    tick();

    // Saturation of a 2-bit counter
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 5; i++) send32(3'd7, $urandom, 2'($urandom_range(0, 3)));
    cmp("sat_err_cnt", {63'd0, ec32}, 65'd3);
    cmp("mode7_out", {oe32, ow32}, {32'd0, 1'b1, 32'h0});
    tick();

    // Reset while both entries are occupied
    or32 = 1'b0;
    send32(3'd0, 32'h0000_5555, 2'd0);
    send32(3'd1, 32'h0000_AAAA, 2'd0);
    cmp("two_full", {64'd0, ir32}, 65'd0);
    #2 rst = 1'b1;
    #1;
    cmp("midrst_outs", {ov32, ir32, oe32, ec32, ow32}, 65'd0);
    tick();
    rst = 1'b0;
    or32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("no_stale", {64'd0, ov32}, 65'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      iv32 = ($urandom_range(0, 3) != 0);
      id32 = $urandom;
      im32 = 3'($urandom_range(0, 7));
      is32 = 2'($urandom_range(0, 3));
      or32 = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv32 = 1'b0; or32 = 1'b1;
    n = 0;
    while (q32.size() != 0 && n < 20) begin tick(); n++; end
    cmp("q32_drained", 65'(q32.size()), 65'd0);

    // 64-bit width
    or64 = 1'b1;
    send64(3'd2, 64'h0000_0000_0000_8000, 3'd0);
    cmp("lui64", {oe64, ow64}, {1'b0, 64'hFFFF_FFFF_8000_0000});
    send64(3'd3, 64'h8000_0000_0000_0000, 3'd7);
    cmp("lb64_sel7", {oe64, ow64}, {1'b0, 64'hFFFF_FFFF_FFFF_FF80});
    for (int i = 0; i < 400; i++) begin
      iv64 = ($urandom_range(0, 3) != 0);
      id64 = {$urandom, $urandom};
      im64 = 3'($urandom_range(0, 7));
      is64 = 3'($urandom_range(0, 7));
      or64 = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv64 = 1'b0; or64 = 1'b1;
    n = 0;
    while (q64.size() != 0 && n < 20) begin tick(); n++; end
    cmp("q64_drained", 65'(q64.size()), 65'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
